addsubcmp_seq_cmp: RTL and testbench
====================================

Name: addsubcmp_seq_cmp

Overview:
- Parametrised, multi-cycle successor to the fixed 16-bit combinational less-than comparator cell.
- Computes D = A - B slice by slice, LSB first, in a SliceWidth-bit ripple.
- Derives carry, zero, sign and overflow flags from D.
- Evaluates one of six selectable relations, unsigned or signed.
- Sits beside the sensor-threshold logic in the WSN SoC and trades latency for area on wide operands.

Parameters:
- Width, 16, operand width in bits. Must be a multiple of SliceWidth.
- SliceWidth, 4, bits processed per cycle. N = Width/SliceWidth calculation cycles.

Ports:
- Clk_i  in  1  clock. All state changes on the rising edge.
- Reset_n_i  in  1  synchronous, active-low reset.
- Start_i  in  1  request. Sampled only when the block is idle or in DONE.
- Mode_i  in  3  relation: 000 A<B, 001 A<=B, 010 A>B, 011 A>=B, 100 A==B, 101 A!=B, 110/111 reserved.
- Signed_i  in  1  1 = two's-complement compare, 0 = unsigned.
- A_i  in  Width  operand A.
- B_i  in  Width  operand B.
- Busy_o  out  1  high while slices are being processed.
- Done_o  out  1  one-cycle pulse when results become valid.
- Result_o  out  1  relation outcome.
- Carry_o  out  1  carry out of A + ~B + 1. 1 = no borrow, i.e. A >= B unsigned.
- Zero_o  out  1  D == 0.
- Sign_o  out  1  D[Width-1].
- Overflow_o  out  1  signed overflow of A - B.

Behaviour:
- Reset (Reset_n_i low at a clock edge):
  - FSM goes to IDLE; all outputs and internal registers are cleared to 0.
  - Applies mid-operation too: the calculation is aborted and no Done_o is produced.
- FSM states: IDLE, CALC, DONE.
- IDLE/DONE, Start_i = 1 at edge k:
  - Latch A_i, B_i, Mode_i, Signed_i.
  - Carry register <- 1; zero-accumulator <- 1; slice counter <- 0.
  - Go to CALC.
- IDLE/DONE, Start_i = 0: DONE goes to IDLE; IDLE stays.
- CALC, each cycle:
  - Add slice i of A, ~B and the carry register.
  - Store the carry out.
  - zero-accumulator &= (slice sum == 0).
  - Increment the counter.
  - On slice N-1, also capture sign = MSB of the sum and overflow = carry into MSB XOR carry out of MSB, then go to DONE.
- Timing, Start accepted at edge k:
  - Busy_o is high during the N cycles after edge k.
  - Done_o and the updated result/flags are high/valid for exactly one cycle after edge k+N.
  - Latency is N+1 edges from Start to the Done_o cycle.
- Start_i while in CALC is ignored and does not restart the calculation.
- Back-to-back operation: Start_i high in the DONE cycle is accepted, giving a throughput of one compare per N+1 cycles.
- Result_o and the flags are registered and hold their values from Done until the next DONE state. They are not cleared by a new Start.
- Relation evaluation:
  - Less = ~Carry when unsigned; Less = Sign XOR Overflow when signed.
  - Equal = Zero.
  - LE = Less | Equal; GT = ~LE; GE = ~Less; NE = ~Equal.
  - Reserved modes give Result_o = 0 with valid flags.
- Overflow_o and Sign_o are reported regardless of Signed_i.
- Width arithmetic is modulo 2^Width; no sign extension.

Optional Feature:
- Macro ADDSUBCMP_SEQ_DIFF_OUT_EN.
- Defined: an extra output port D_o (out, Width bits) gives the full difference A - B mod 2^Width.
  - Assembled slice by slice and registered.
  - Valid from the Done_o cycle, held like the flags, reset to 0.
- Undefined: no D_o port. Only the current slice sum is kept internally, so no Width-bit difference register is built.

Test Plan (Width=16, SliceWidth=4, N=4):
- A=0x0003, B=0x0005, Mode=000, Signed=0, Start at edge k -> Busy_o high for 4 cycles; Done_o only in cycle k+5. Result=1, Carry=0, Zero=0, Sign=1, Overflow=0; D_o=0xFFFE if enabled.
- A=0xFFFF, B=0x0001, Mode=000 -> Signed=1 gives Result=1 (-1<1). Signed=0 gives Result=0, Carry=1.
- A=B=0x1234 -> Mode 100 gives Result=1, Zero=1, Carry=1. Mode 001 gives 1; modes 000 and 010 give 0.
- A=0x8000, B=0x0001, Signed=1, Mode=000 -> Overflow=1, Sign=0, Result=1. Same with Mode=011 -> Result=0.
- Start again during CALC with new operands -> ignored; the original result appears at the original Done cycle. Start held high in the DONE cycle -> second compare completes exactly 5 cycles later.
- Reset_n_i low at edge k+2 of a compare -> the next cycle shows all outputs 0 and IDLE; Done_o never pulses for the aborted compare.

Source files
------------

// File: rtl/addsubcmp_seq_cmp.sv
// Sequential slice-wise A - B comparator: one SliceWidth-bit ripple step per cycle, six relations.
// Optional ADDSUBCMP_SEQ_DIFF_OUT_EN adds the registered full difference on D_o.
//
// state  | meaning
// IDLE   | waiting for Start_i
// CALC   | one slice of A + ~B + carry per cycle, LSB first
// DONE   | Done_o pulse; result and flags valid; Start_i accepted again
module addsubcmp_seq_cmp #(
  parameter int Width      = 16,
  parameter int SliceWidth = 4
) (
  input  logic             Clk_i,
  input  logic             Reset_n_i,
  input  logic             Start_i,
  input  logic [2:0]       Mode_i,
  input  logic             Signed_i,
  input  logic [Width-1:0] A_i,
  input  logic [Width-1:0] B_i,
  output logic             Busy_o,
  output logic             Done_o,
  output logic             Result_o,
  output logic             Carry_o,
  output logic             Zero_o,
  output logic             Sign_o,
`ifdef ADDSUBCMP_SEQ_DIFF_OUT_EN
  output logic             Overflow_o,
  output logic [Width-1:0] D_o
`else
  output logic             Overflow_o
`endif
);

  localparam int N  = Width / SliceWidth;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q;
  logic [Width-1:0] a_q, b_q;
  logic [2:0]       mode_q;
  logic             signed_q;
  logic             carry_q;
  logic             zacc_q;
  logic [CW-1:0]    cnt_q;

  logic [SliceWidth-1:0] a_sl, nb_sl, sum_sl;
  logic                  c_out, c_msb, ovf_fin, zero_fin, less, equal, rel;

  always_comb begin
    a_sl  = a_q[SliceWidth-1:0];
    nb_sl = ~b_q[SliceWidth-1:0];
    {c_out, sum_sl} = {1'b0, a_sl} + {1'b0, nb_sl} + {{SliceWidth{1'b0}}, carry_q};
    // carry into the MSB recovered from the MSB sum bit, so SliceWidth = 1 also works
    c_msb    = sum_sl[SliceWidth-1] ^ a_sl[SliceWidth-1] ^ nb_sl[SliceWidth-1];
    ovf_fin  = c_msb ^ c_out;
    zero_fin = zacc_q & (sum_sl == '0);
    less     = signed_q ? (sum_sl[SliceWidth-1] ^ ovf_fin) : ~c_out;
    equal    = zero_fin;
    rel      = 1'b0;
    case (mode_q)
      3'b000:  rel = less;
      3'b001:  rel = less | equal;
      3'b010:  rel = ~(less | equal);
      3'b011:  rel = ~less;
      3'b100:  rel = equal;
      3'b101:  rel = ~equal;
      default: rel = 1'b0;
    endcase
  end

  assign Busy_o = (state_q == S_CALC);
  assign Done_o = (state_q == S_DONE);

  always_ff @(posedge Clk_i) begin
    if (!Reset_n_i) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      mode_q     <= '0;
      signed_q   <= 1'b0;
      carry_q    <= 1'b0;
      zacc_q     <= 1'b0;
      cnt_q      <= '0;
      Result_o   <= 1'b0;
      Carry_o    <= 1'b0;
      Zero_o     <= 1'b0;
      Sign_o     <= 1'b0;
      Overflow_o <= 1'b0;
    end else begin
      case (state_q)
        S_CALC: begin
          a_q     <= a_q >> SliceWidth;
          b_q     <= b_q >> SliceWidth;
          carry_q <= c_out;
          zacc_q  <= zero_fin;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q    <= S_DONE;
            Result_o   <= rel;
            Carry_o    <= c_out;
            Zero_o     <= zero_fin;
            Sign_o     <= sum_sl[SliceWidth-1];
            Overflow_o <= ovf_fin;
          end
        end
        default: begin
          if (Start_i) begin
            state_q  <= S_CALC;
            a_q      <= A_i;
            b_q      <= B_i;
            mode_q   <= Mode_i;
            signed_q <= Signed_i;
            carry_q  <= 1'b1;
            zacc_q   <= 1'b1;
            cnt_q    <= '0;
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

`ifdef ADDSUBCMP_SEQ_DIFF_OUT_EN
  // slices enter at the top and shift down, so after N steps slice 0 sits at the LSB
  logic [Width-1:0]            d_acc_q;
  logic [Width+SliceWidth-1:0] d_cat;

  assign d_cat = {sum_sl, d_acc_q};

  always_ff @(posedge Clk_i) begin
    if (!Reset_n_i) begin
      d_acc_q <= '0;
      D_o     <= '0;
    end else if (state_q == S_CALC) begin
      d_acc_q <= d_cat[Width+SliceWidth-1:SliceWidth];
      if (cnt_q == LAST) D_o <= d_cat[Width+SliceWidth-1:SliceWidth];
    end
  end
`endif

endmodule

// File: tb/tb_addsubcmp_seq_cmp.sv
// Self-checking bench for addsubcmp_seq_cmp (Width=16, SliceWidth=4): fixed vectors,
// multi-cycle corner sequences and random compares against an arithmetic reference.
module tb_addsubcmp_seq_cmp;
  localparam int W = 16;
  localparam int N = 4;

  logic          clk, rst_n, start, sgn;
  logic [2:0]    mode;
  logic [W-1:0]  a, b;
  logic          busy, done, result, carry, zero, sign, ovf;
`ifdef ADDSUBCMP_SEQ_DIFF_OUT_EN
  logic [W-1:0]  d_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  addsubcmp_seq_cmp #(.Width(W), .SliceWidth(4)) dut (
    .Clk_i(clk), .Reset_n_i(rst_n), .Start_i(start), .Mode_i(mode), .Signed_i(sgn),
    .A_i(a), .B_i(b), .Busy_o(busy), .Done_o(done), .Result_o(result), .Carry_o(carry),
    .Zero_o(zero), .Sign_o(sign),
`ifdef ADDSUBCMP_SEQ_DIFF_OUT_EN
    .Overflow_o(ovf), .D_o(d_o)
`else
    .Overflow_o(ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   mode;
    logic         sgn;
    logic [4:0]   exp;   // {result, carry, zero, sign, overflow}
    logic [W-1:0] exp_d;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] flags();
    return {result, carry, zero, sign, ovf};
  endfunction

  // Reference: plain integer arithmetic on the operands, no slicing
  function automatic logic [4:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic [2:0] mm, input logic ms);
    logic [W-1:0] d;
    int sa, sb, sd;
    logic less, eq, r;
    d  = ma - mb;
    sa = $signed(ma);
    sb = $signed(mb);
    sd = sa - sb;
    less = ms ? (sa < sb) : (ma < mb);
    eq   = (ma == mb);
    case (mm)
      3'd0: r = less;
      3'd1: r = less || eq;
      3'd2: r = !(less || eq);
      3'd3: r = !less;
      3'd4: r = eq;
      3'd5: r = !eq;
      default: r = 1'b0;
    endcase
    return {r, ma >= mb, eq, d[W-1], (sd > 32767) || (sd < -32768)};
  endfunction

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [2:0] im, input logic is);
    a = ia; b = ib; mode = im; sgn = is; start = 1'b1;
  endtask

  // Start is sampled at the next edge (k); Done must show exactly after edge k+N
  task automatic finish_op(input string tag, input logic [4:0] exp, input logic [W-1:0] exp_d);
    int bad;
    bad = 0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!busy || done) bad++;
      @(posedge clk); #1;
    end
    chk({tag, " busy_window"}, bad, 0);
    chk({tag, " done_pulse"}, {busy, done}, 2'b01);
    chk({tag, " flags"}, flags(), exp);
`ifdef ADDSUBCMP_SEQ_DIFF_OUT_EN
    chk({tag, " diff"}, d_o, exp_d);
`else
    if (exp_d !== exp_d) n_bad++;
`endif
  endtask

  task automatic idle_hold(input string tag, input logic [4:0] exp);
    @(posedge clk); #1;
    chk({tag, " done_drop"}, {busy, done}, 2'b00);
    chk({tag, " hold"}, flags(), exp);
  endtask

  initial begin
    vecs[0]  = '{16'h0003, 16'h0005, 3'd0, 1'b0, 5'b10010, 16'hFFFE};
    vecs[1]  = '{16'hFFFF, 16'h0001, 3'd0, 1'b1, 5'b11010, 16'hFFFE};
    vecs[2]  = '{16'hFFFF, 16'h0001, 3'd0, 1'b0, 5'b01010, 16'hFFFE};
    vecs[3]  = '{16'h1234, 16'h1234, 3'd4, 1'b0, 5'b11100, 16'h0000};
    vecs[4]  = '{16'h1234, 16'h1234, 3'd1, 1'b0, 5'b11100, 16'h0000};
    vecs[5]  = '{16'h1234, 16'h1234, 3'd0, 1'b0, 5'b01100, 16'h0000};
    vecs[6]  = '{16'h1234, 16'h1234, 3'd2, 1'b0, 5'b01100, 16'h0000};
    vecs[7]  = '{16'h8000, 16'h0001, 3'd0, 1'b1, 5'b11001, 16'h7FFF};
    vecs[8]  = '{16'h8000, 16'h0001, 3'd3, 1'b1, 5'b01001, 16'h7FFF};
    vecs[9]  = '{16'h0003, 16'h0005, 3'd6, 1'b0, 5'b00010, 16'hFFFE};
    vecs[10] = '{16'h0005, 16'h0003, 3'd2, 1'b1, 5'b11000, 16'h0002};
    vecs[11] = '{16'h7FFF, 16'h8000, 3'd2, 1'b1, 5'b10011, 16'hFFFF};

    rst_n = 1'b0; start = 1'b0; mode = '0; sgn = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", {busy, done, flags()}, 7'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].sgn);
      finish_op($sformatf("vec%0d", i), vecs[i].exp, vecs[i].exp_d);
      idle_hold($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Start during CALC with new operands is ignored
    begin
      int extra;
      issue(16'h0003, 16'h0005, 3'd0, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 1; i <= N; i++) begin
        if (i == 2) issue(16'h0005, 16'h0003, 3'd0, 1'b0);
        else start = 1'b0;
        @(posedge clk); #1;
      end
      chk("calc_start done", {busy, done}, 2'b01);
      chk("calc_start flags", flags(), 5'b10010);
      extra = 0;
      for (int i = 0; i < N + 2; i++) begin
        @(posedge clk); #1;
        if (busy || done) extra++;
      end
      chk("calc_start no_restart", extra, 0);
    end

    // Back-to-back: Start held in the DONE cycle, second Done N+1 cycles later
    issue(16'h1234, 16'h1234, 3'd5, 1'b0);
    finish_op("b2b first", 5'b01100, 16'h0000);
    issue(16'h8000, 16'h0001, 3'd0, 1'b1);
    finish_op("b2b second", 5'b11001, 16'h7FFF);
    idle_hold("b2b second", 5'b11001);

    // Reset at edge k+2 aborts the compare
    begin
      int spur;
      issue(16'hFFFF, 16'h0001, 3'd0, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("abort outputs", {busy, done, flags()}, 7'b0);
`ifdef ADDSUBCMP_SEQ_DIFF_OUT_EN
      chk("abort diff", d_o, 0);
`endif
      rst_n = 1'b1;
      spur = 0;
      for (int i = 0; i < N + 2; i++) begin
        @(posedge clk); #1;
        if (busy || done) spur++;
      end
      chk("abort no_done", spur, 0);
    end

    // Random compares, mixing back-to-back and idle gaps
    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] ra, rb;
      logic [2:0]   rm;
      logic         rs;
      logic [4:0]   e;
      ra = W'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? ra : W'($urandom);
      if ($urandom_range(0, 7) == 0) ra = 16'h8000;
      rm = 3'($urandom_range(0, 7));
      rs = 1'($urandom);
      e  = model(ra, rb, rm, rs);
      issue(ra, rb, rm, rs);
      finish_op($sformatf("rnd%0d", i), e, ra - rb);
      if ($urandom_range(0, 1) == 0) idle_hold($sformatf("rnd%0d", i), e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
